// File: rtl/det_pkg.sv
// Shared defaults and state encoding for the sequential Bareiss determinant block.
package det_pkg;

  localparam int unsigned DEF_N_MAX = 5;
  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_ACC_W = 48;
  localparam int unsigned DEF_RW    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PIVOT,
    SWAP,
    UPDATE,
    DIVW,
    FINISH
  } state_t;

endpackage

// File: rtl/det_div_seq.sv
// Signed restoring divider: double-width dividend over W-bit divisor, W-bit quotient.
// The quotient must fit in W bits (true for exact Bareiss divisions); done follows start by W+2 cycles.
module det_div_seq
  import det_pkg::*;
#(
  parameter int unsigned W = DEF_ACC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [2*W-1:0] dividend,
  input  logic signed [W-1:0]   divisor,
  output logic signed [W-1:0]   quotient,
  output logic                  done
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   dvs;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic           run;
  logic           fin;

  logic [2*W-1:0] mag_c;
  logic [W:0]     sh_c;
  logic           ge_c;
  logic [W-1:0]   diff_c;

  always_comb begin
    mag_c  = dividend[2*W-1] ? (2*W)'(-dividend) : (2*W)'(dividend);
    sh_c   = {rem, quo[W-1]};
    ge_c   = (sh_c >= {1'b0, dvs});
    diff_c = W'(sh_c - {1'b0, dvs});
  end

  // One quotient bit per cycle, then a sign-fix cycle that raises done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      run      <= 1'b0;
      fin      <= 1'b0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !run && !fin) begin
        rem <= mag_c[2*W-1:W];
        quo <= mag_c[W-1:0];
        dvs <= divisor[W-1] ? W'(-divisor) : W'(divisor);
        neg <= dividend[2*W-1] ^ divisor[W-1];
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        rem <= ge_c ? diff_c : sh_c[W-1:0];
        quo <= {quo[W-2:0], ge_c};
        cnt <= cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          run <= 1'b0;
          fin <= 1'b1;
        end
      end else if (fin) begin
        fin      <= 1'b0;
        done     <= 1'b1;
        quotient <= neg ? -$signed(quo) : $signed(quo);
      end
    end
  end

endmodule

// File: rtl/mod_det_seq.sv
// Sequential determinant of the top-left n x n submatrix using fraction-free Bareiss
// elimination, with row pivoting and a saturated signed result.
module mod_det_seq
  import det_pkg::*;
#(
  parameter int unsigned N_MAX = DEF_N_MAX,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned RW    = DEF_RW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2:0]                size,
  input  logic [N_MAX*N_MAX*DW-1:0] mat_in,
  output logic signed [RW-1:0]      resultado,
  output logic                      done,
  output logic                      busy,
  output logic                      ovf,
  output logic                      err
);

  localparam int unsigned PW = 2 * ACC_W;
  localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN = {{(ACC_W-RW+1){1'b1}}, {(RW-1){1'b0}}};

  state_t state, state_nxt;

  logic [2:0]              n, k, r, i, j;
  logic                    neg, zero, bad;
  logic signed [ACC_W-1:0] prev;
  logic signed [ACC_W-1:0] a     [N_MAX][N_MAX];
  logic signed [ACC_W-1:0] m_ext [N_MAX][N_MAX];

  logic                    accept_c, size_bad_c, piv_nz_c, last_i_c, last_j_c;
  logic                    adv_c, div_start_c, div_done;
  logic [2:0]              n_m1_c, k_p1_c, fin_idx_c;
  logic signed [PW-1:0]    num_c;
  logic signed [ACC_W-1:0] div_q, det_c;

  for (genvar gr = 0; gr < N_MAX; gr++) begin : g_row
    for (genvar gc = 0; gc < N_MAX; gc++) begin : g_col
      assign m_ext[gr][gc] = ACC_W'($signed(mat_in[(gr*N_MAX+gc)*DW +: DW]));
    end
  end

  // Datapath decode; the cross product is kept double width so the divide sees it exactly.
  always_comb begin
    n_m1_c     = n - 3'd1;
    k_p1_c     = k + 3'd1;
    accept_c   = (state == IDLE) && start && !done;
    size_bad_c = (n == 3'd0) || (n > 3'(N_MAX));
    piv_nz_c   = (a[r][k] != '0);
    last_i_c   = (i == n_m1_c);
    last_j_c   = (j == n_m1_c);
    num_c      = PW'(a[i][j]) * PW'(a[k][k]) - PW'(a[i][k]) * PW'(a[k][j]);
    fin_idx_c  = bad ? 3'd0 : n_m1_c;
    det_c      = neg ? -a[fin_idx_c][fin_idx_c] : a[fin_idx_c][fin_idx_c];
  end

  always_comb begin
    state_nxt   = state;
    adv_c       = 1'b0;
    div_start_c = 1'b0;
    case (state)
      IDLE:   if (accept_c) state_nxt = LOAD;
      LOAD:   state_nxt = (size_bad_c || n == 3'd1) ? FINISH : PIVOT;
      PIVOT: begin
        if (piv_nz_c)         state_nxt = (r == k) ? UPDATE : SWAP;
        else if (r == n_m1_c) state_nxt = FINISH;
      end
      SWAP:   state_nxt = UPDATE;
      UPDATE: begin
        if (k == 3'd0) begin
          adv_c = 1'b1;
        end else begin
          div_start_c = 1'b1;
          state_nxt   = DIVW;
        end
      end
      DIVW:   if (div_done) adv_c = 1'b1;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (adv_c) begin
      if (last_i_c && last_j_c) state_nxt = (k_p1_c == n_m1_c) ? FINISH : PIVOT;
      else                      state_nxt = UPDATE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Control registers, element cursors and the held result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= '0; k <= '0; r <= '0; i <= '0; j <= '0;
      neg       <= 1'b0;
      zero      <= 1'b0;
      bad       <= 1'b0;
      prev      <= '0;
      resultado <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            n    <= size;
            busy <= 1'b1;
            ovf  <= 1'b0;
            err  <= 1'b0;
          end
        end
        LOAD: begin
          k    <= '0;
          r    <= '0;
          prev <= ACC_W'(1);
          neg  <= 1'b0;
          zero <= 1'b0;
          bad  <= size_bad_c;
        end
        PIVOT: begin
          if (piv_nz_c) begin
            i <= k_p1_c;
            j <= k_p1_c;
          end else if (r == n_m1_c) begin
            zero <= 1'b1;
          end else begin
            r <= r + 3'd1;
          end
        end
        SWAP: neg <= ~neg;
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (bad) begin
            resultado <= '0;
            err       <= 1'b1;
          end else if (zero) begin
            resultado <= '0;
          end else if (det_c > RES_MAX) begin
            resultado <= RES_MAX[RW-1:0];
            ovf       <= 1'b1;
          end else if (det_c < RES_MIN) begin
            resultado <= RES_MIN[RW-1:0];
            ovf       <= 1'b1;
          end else begin
            resultado <= det_c[RW-1:0];
          end
        end
        default: ;
      endcase
      if (adv_c) begin
        if (last_j_c) begin
          j <= k_p1_c;
          if (last_i_c) begin
            prev <= a[k][k];
            k    <= k_p1_c;
            r    <= k_p1_c;
          end else begin
            i <= i + 3'd1;
          end
        end else begin
          j <= j + 3'd1;
        end
      end
    end
  end

  // Working matrix; contents are only meaningful between an accepted start and done.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      a <= m_ext;
    end else if (state == SWAP) begin
      for (int cc = 0; cc < N_MAX; cc++) begin
        a[k][3'(cc)] <= a[r][3'(cc)];
        a[r][3'(cc)] <= a[k][3'(cc)];
      end
    end else if (adv_c) begin
      a[i][j] <= (k == 3'd0) ? ACC_W'(num_c) : div_q;
    end
  end

  det_div_seq #(
    .W(ACC_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_c),
    .dividend (num_c),
    .divisor  (prev),
    .quotient (div_q),
    .done     (div_done)
  );

endmodule

// File: tb/tb_mod_det_seq.sv
// Directed bench for mod_det_seq: hand-computed determinants, saturation, illegal sizes,
// start filtering while busy or in the done cycle, and reset mid-operation.
module tb_mod_det_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [2:0]         size;
  logic [199:0]       mat_in;
  logic signed [15:0] resultado;
  logic               done, busy, ovf, err;

  int errors = 0;
  int checks = 0;
  int lat, nd;

  always #5 clk = ~clk;

  mod_det_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .size      (size),
    .mat_in    (mat_in),
    .resultado (resultado),
    .done      (done),
    .busy      (busy),
    .ovf       (ovf),
    .err       (err)
  );

  task automatic set_el(input int rr, input int cc, input int v);
    mat_in[(rr*5+cc)*8 +: 8] = 8'(v);
  endtask

  task automatic set_diag(input int nn, input int v);
    mat_in = '0;
    for (int d = 0; d < nn; d++) set_el(d, d, v);
  endtask

  task automatic load_basic3();
    mat_in = '0;
    set_el(0, 0, 2); set_el(0, 1, 0); set_el(0, 2, 1);
    set_el(1, 0, 1); set_el(1, 1, 3); set_el(1, 2, 2);
    set_el(2, 0, 1); set_el(2, 1, 1); set_el(2, 2, 4);
  endtask

  // Pulse start from a negedge, wait (bounded) for done, then count done pulses a bit longer.
  task automatic run_op(input logic [2:0] sz, output int l, output int ndone);
    size  = sz;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l     = 1;
    ndone = 0;
    while (!done && l < 2000) begin
      @(negedge clk);
      l++;
    end
    if (done) ndone = 1;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; size = '0; mat_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (resultado !== 16'sd0) begin errors++; $display("FAIL reset_res: got %0d want 0", resultado); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    set_diag(5, 1);
    run_op(3'd5, lat, nd);
    checks++; if (resultado !== 16'sd1) begin errors++; $display("FAIL ident_res: got %0d want 1", resultado); end
    checks++; if (ovf !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL ident_flags: got ovf=%b err=%b want 0 0", ovf, err); end
    checks++; if (lat > 800) begin errors++; $display("FAIL ident_latency: got %0d want <=800", lat); end
    checks++; if (nd != 1) begin errors++; $display("FAIL ident_done_count: got %0d want 1", nd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ident_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_basic3();
    load_basic3();
    run_op(3'd3, lat, nd);
    checks++; if (resultado !== 16'sd18) begin errors++; $display("FAIL basic3_res: got %0d want 18", resultado); end
  endtask

  task automatic test_pivot();
    mat_in = '0;
    set_el(0, 1, 1); set_el(1, 0, 1);
    run_op(3'd2, lat, nd);
    checks++; if (resultado !== -16'sd1) begin errors++; $display("FAIL swap_res: got %0d want -1", resultado); end
    mat_in = '0;
    set_el(0, 1, 1); set_el(0, 2, 2);
    set_el(1, 1, 3); set_el(1, 2, 4);
    set_el(2, 1, 5); set_el(2, 2, 6);
    run_op(3'd3, lat, nd);
    checks++; if (resultado !== 16'sd0) begin errors++; $display("FAIL zerocol_res: got %0d want 0", resultado); end
    checks++; if (nd != 1) begin errors++; $display("FAIL zerocol_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_saturation();
    mat_in = '0;
    set_el(0, 0, -128); set_el(1, 1, 127); set_el(2, 2, 2);
    run_op(3'd3, lat, nd);
    checks++; if (resultado !== -16'sd32512 || ovf !== 1'b0) begin errors++; $display("FAIL sat_inrange: got %0d ovf=%b want -32512 ovf=0", resultado, ovf); end
    set_diag(3, -128);
    run_op(3'd3, lat, nd);
    checks++; if (resultado !== -16'sd32768 || ovf !== 1'b1) begin errors++; $display("FAIL sat_neg: got %0d ovf=%b want -32768 ovf=1", resultado, ovf); end
    set_diag(5, 127);
    run_op(3'd5, lat, nd);
    checks++; if (resultado !== 16'sd32767 || ovf !== 1'b1) begin errors++; $display("FAIL sat_pos: got %0d ovf=%b want 32767 ovf=1", resultado, ovf); end
    checks++; if (lat > 800) begin errors++; $display("FAIL sat_pos_latency: got %0d want <=800", lat); end
  endtask

  task automatic test_illegal();
    set_diag(5, 1);
    run_op(3'd0, lat, nd);
    checks++; if (err !== 1'b1 || resultado !== 16'sd0 || ovf !== 1'b0) begin errors++; $display("FAIL size0: got err=%b res=%0d ovf=%b want 1 0 0", err, resultado, ovf); end
    checks++; if (nd != 1) begin errors++; $display("FAIL size0_done_count: got %0d want 1", nd); end
    run_op(3'd6, lat, nd);
    checks++; if (err !== 1'b1 || resultado !== 16'sd0) begin errors++; $display("FAIL size6: got err=%b res=%0d want 1 0", err, resultado); end
    checks++; if (nd != 1) begin errors++; $display("FAIL size6_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_ignored_start();
    int cyc;
    load_basic3();
    size  = 3'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ign_err_cleared: got %b want 0", err); end
    set_diag(5, 1);
    size  = 3'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    nd  = 0;
    while (cyc < 1000) begin
      if (done) nd++;
      @(negedge clk);
      cyc++;
    end
    checks++; if (resultado !== 16'sd18) begin errors++; $display("FAIL ign_res: got %0d want 18", resultado); end
    checks++; if (nd != 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_done_cycle_start();
    int cyc;
    mat_in = '0;
    set_el(0, 0, 3); set_el(0, 1, 1); set_el(1, 0, 4); set_el(1, 1, 2);
    size  = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dc_done_seen: got %b want 1", done); end
    load_basic3();
    size  = 3'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dc_start_ignored: busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (resultado !== 16'sd2) begin errors++; $display("FAIL dc_res_held: got %0d want 2", resultado); end
    run_op(3'd3, lat, nd);
    checks++; if (resultado !== 16'sd18 || nd != 1) begin errors++; $display("FAIL dc_next_start: got %0d done_count=%0d want 18 1", resultado, nd); end
  endtask

  task automatic test_reset_mid();
    set_diag(5, 1);
    size  = 3'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (resultado !== 16'sd0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rmid_async_clear: got res=%0d busy=%b done=%b ovf=%b err=%b want all 0", resultado, busy, done, ovf, err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (900) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL rmid_no_done: got %0d pulses want 0", nd); end
    mat_in = '0;
    set_el(0, 0, 3); set_el(0, 1, 1); set_el(1, 0, 4); set_el(1, 1, 2);
    run_op(3'd2, lat, nd);
    checks++; if (resultado !== 16'sd2 || nd != 1) begin errors++; $display("FAIL rmid_after: got %0d done_count=%0d want 2 1", resultado, nd); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_basic3();
    test_pivot();
    test_saturation();
    test_illegal();
    test_ignored_start();
    test_done_cycle_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
